// File: rtl/axi_lite_master_if.sv
// Core load/store request/response signals plus the AXI4-Lite bus of axi_lite_master.
// The master modport is the initiator's view; the slave modport is the core/peripheral side.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;

  logic [ADDR_W-1:0]     axi_araddr;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [2:0]            axi_arprot;
  logic [DATA_W-1:0]     axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [ADDR_W-1:0]     axi_awaddr;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [2:0]            axi_awprot;
  logic [DATA_W-1:0]     axi_wdata;
  logic [DATA_W/8-1:0]   axi_wstrb;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one core load/store becomes one AXI-Lite
// read or write, completing with a one-cycle resp_valid pulse.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_lite_master_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_D, S_WR, S_WR_B} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  logic w_req_ready, w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
  logic w_accept, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_done;
  logic w_unused_resp_bits;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_ar_hs   = w_arvalid && bus.axi_arready;
  assign w_r_hs    = w_rready  && bus.axi_rvalid;
  assign w_aw_hs   = w_awvalid && bus.axi_awready;
  assign w_w_hs    = w_wvalid  && bus.axi_wready;
  assign w_b_hs    = w_bready  && bus.axi_bvalid;
  // Address and data phases may finish in either order or together.
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // Only the error bit of the response code matters to the core.
  assign w_unused_resp_bits = bus.axi_rresp[0] ^ bus.axi_bresp[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_state_next = bus.req_we ? S_WR : S_RD_A;
      S_RD_A:  if (w_ar_hs)       w_state_next = S_RD_D;
      S_RD_D:  if (w_r_hs)        w_state_next = S_IDLE;
      S_WR:    if (w_wr_done)     w_state_next = S_WR_B;
      S_WR_B:  if (w_b_hs)        w_state_next = S_IDLE;
      default:                    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    case (r_state)
      S_IDLE: w_req_ready = 1'b1;
      S_RD_A: w_arvalid   = 1'b1;
      S_RD_D: w_rready    = 1'b1;
      S_WR: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      S_WR_B: w_bready    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_r_hs || w_b_hs;
      if (w_accept) begin
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_wstrb   <= bus.req_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_r_hs) begin
        r_resp_rdata <= bus.axi_rdata;
        r_resp_err   <= bus.axi_rresp[1];
      end
      if (w_b_hs) begin
        r_resp_rdata <= '0;
        r_resp_err   <= bus.axi_bresp[1];
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_rdata  = r_resp_rdata;
  assign bus.resp_err    = r_resp_err;
  assign bus.axi_araddr  = r_addr;
  assign bus.axi_arvalid = w_arvalid;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_rready  = w_rready;
  assign bus.axi_awaddr  = r_addr;
  assign bus.axi_awvalid = w_awvalid;
  assign bus.axi_awprot  = 3'b000;
  assign bus.axi_wdata   = r_wdata;
  assign bus.axi_wstrb   = r_wstrb;
  assign bus.axi_wvalid  = w_wvalid;
  assign bus.axi_bready  = w_bready;
endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: a delay-programmable AXI-Lite slave with a
// 16-word window at 0x4000, and a scoreboard predicting data, error and cycle timing.
module tb_axi_lite_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          acc;
    int          ar, r, aw, w, b;
  } txn_t;

  txn_t        pend[$];
  logic [31:0] smem [16];
  logic [31:0] mmem [16];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          k_ar = 0, k_r = 0, k_aw = 0, k_w = 0, k_b = 0;
  logic [1:0]  k_err = 2'b10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return a[31:6] == 26'h100;
  endfunction

  // ---------------- AXI-Lite slave ----------------
  int          s_ar_c, s_r_c, s_aw_c, s_w_c, s_b_c;
  bit          s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;
  bit          s_r_busy, s_b_busy, s_have_aw, s_have_w;
  logic [31:0] s_ar_a, s_aw_a, s_w_d;
  logic [3:0]  s_w_s;
  logic [1:0]  s_b_code;
  logic        s_ok_bit;

  initial begin : slave
    {s_ar_c, s_r_c, s_aw_c, s_w_c, s_b_c} = '0;
    forever begin
      if (rst) begin
        bus.axi_arready = 1'b0; bus.axi_rvalid = 1'b0; bus.axi_rdata = '0; bus.axi_rresp = '0;
        bus.axi_awready = 1'b0; bus.axi_wready = 1'b0; bus.axi_bvalid = 1'b0; bus.axi_bresp = '0;
        {s_ar_c, s_r_c, s_aw_c, s_w_c, s_b_c} = '0;
        {s_r_busy, s_b_busy, s_have_aw, s_have_w} = '0;
        s_ar_a = '0; s_aw_a = '0; s_w_d = '0; s_w_s = '0; s_b_code = '0;
      end else begin
        if (s_ar_hs) begin bus.axi_arready = 1'b0; s_ar_c = 0; s_r_busy = 1'b1; s_r_c = 0; end
        if (s_r_hs)  begin bus.axi_rvalid = 1'b0; s_r_busy = 1'b0; end
        if (s_aw_hs) begin bus.axi_awready = 1'b0; s_aw_c = 0; s_have_aw = 1'b1; end
        if (s_w_hs)  begin bus.axi_wready = 1'b0; s_w_c = 0; s_have_w = 1'b1; end
        if (s_b_hs)  begin bus.axi_bvalid = 1'b0; s_b_busy = 1'b0; end
        if (s_have_aw && s_have_w) begin
          if (mapped(s_aw_a))
            for (int i = 0; i < 4; i++)
              if (s_w_s[i]) smem[s_aw_a[5:2]][8*i +: 8] = s_w_d[8*i +: 8];
          s_ok_bit = 1'($urandom_range(0, 1));
          s_b_code = mapped(s_aw_a) ? {1'b0, s_ok_bit} : k_err;
          s_have_aw = 1'b0; s_have_w = 1'b0; s_b_busy = 1'b1; s_b_c = 0;
        end
        if (bus.axi_arvalid && !bus.axi_arready) begin
          if (s_ar_c >= k_ar) bus.axi_arready = 1'b1; else s_ar_c++;
        end
        if (s_r_busy && !bus.axi_rvalid) begin
          if (s_r_c >= k_r) begin
            s_ok_bit = 1'($urandom_range(0, 1));
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = mapped(s_ar_a) ? smem[s_ar_a[5:2]] : 32'hDEADBEEF;
            bus.axi_rresp  = mapped(s_ar_a) ? {1'b0, s_ok_bit} : k_err;
          end else s_r_c++;
        end
        if (bus.axi_awvalid && !bus.axi_awready) begin
          if (s_aw_c >= k_aw) bus.axi_awready = 1'b1; else s_aw_c++;
        end
        if (bus.axi_wvalid && !bus.axi_wready) begin
          if (s_w_c >= k_w) bus.axi_wready = 1'b1; else s_w_c++;
        end
        if (s_b_busy && !bus.axi_bvalid) begin
          if (s_b_c >= k_b) begin bus.axi_bvalid = 1'b1; bus.axi_bresp = s_b_code; end
          else s_b_c++;
        end
      end
      // Handshakes that will complete at the coming rising edge.
      s_ar_hs = bus.axi_arvalid && bus.axi_arready; if (s_ar_hs) s_ar_a = bus.axi_araddr;
      s_r_hs  = bus.axi_rvalid  && bus.axi_rready;
      s_aw_hs = bus.axi_awvalid && bus.axi_awready; if (s_aw_hs) s_aw_a = bus.axi_awaddr;
      s_w_hs  = bus.axi_wvalid  && bus.axi_wready;
      if (s_w_hs) begin s_w_d = bus.axi_wdata; s_w_s = bus.axi_wstrb; end
      s_b_hs  = bus.axi_bvalid  && bus.axi_bready;
      @(negedge clk);
    end
  end

  // ---------------- response monitor / reference model ----------------
  int  n_arv, n_awv, n_wv, bready_cyc, n_resp;
  bit  overlap;

  initial begin : monitor
    txn_t        t;
    logic [31:0] exp_d, mask;
    bit          exp_e;
    int          m;
    n_resp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_arv = 0; n_awv = 0; n_wv = 0; bready_cyc = -1; overlap = 1'b0;
        pend.delete();
      end else begin
        if (bus.axi_arvalid) n_arv++;
        if (bus.axi_awvalid) n_awv++;
        if (bus.axi_wvalid)  n_wv++;
        if (bus.axi_bready && bready_cyc < 0) bready_cyc = cyc;
        if ((bus.axi_arvalid || bus.axi_rready) &&
            (bus.axi_awvalid || bus.axi_wvalid || bus.axi_bready)) overlap = 1'b1;
        if (bus.resp_valid) begin
          n_resp++;
          if (pend.size() == 0) check("spurious_resp", 1, 0);
          else begin
            t = pend.pop_front();
            exp_e = !mapped(t.addr);
            if (t.we) begin
              exp_d = 32'h0;
              mask  = {{8{t.wstrb[3]}}, {8{t.wstrb[2]}}, {8{t.wstrb[1]}}, {8{t.wstrb[0]}}};
              if (!exp_e) mmem[t.addr[5:2]] = (mmem[t.addr[5:2]] & ~mask) | (t.wdata & mask);
              m = (t.aw > t.w) ? t.aw : t.w;
              check("latency", cyc - t.acc, m + t.b + 3);
              check("awvalid_cycles", n_awv, t.aw + 1);
              check("wvalid_cycles", n_wv, t.w + 1);
              check("bready_cycle", bready_cyc - t.acc, m + 2);
              check("arvalid_cycles", n_arv, 0);
            end else begin
              exp_d = exp_e ? 32'hDEADBEEF : mmem[t.addr[5:2]];
              check("latency", cyc - t.acc, t.ar + t.r + 3);
              check("arvalid_cycles", n_arv, t.ar + 1);
              check("aw_w_cycles", n_awv + n_wv, 0);
            end
            check("resp_rdata", bus.resp_rdata, exp_d);
            check("resp_err", bus.resp_err, exp_e);
            check("no_overlap", overlap, 0);
          end
          n_arv = 0; n_awv = 0; n_wv = 0; bready_cyc = -1; overlap = 1'b0;
        end
      end
    end
  end

  // ---------------- core-side driver ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int ar, input int r, input int aw,
                       input int w, input int b, input logic [1:0] err, output bit with_resp);
    txn_t t;
    bit   ok = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept", ok, 1);
    with_resp = bus.resp_valid;
    if (ok) begin
      k_ar = ar; k_r = r; k_aw = aw; k_w = w; k_b = b; k_err = err;
      t.we = we; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb; t.acc = cyc;
      t.ar = ar; t.r = r; t.aw = aw; t.w = w; t.b = b;
      pend.push_back(t);
    end
  endtask

  task automatic drop_req();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input int lim);
    int i = 0;
    while (pend.size() != 0 && i < lim) begin @(negedge clk); i++; end
    check("resp_timeout", pend.size(), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit          wr;
    bit          bad;
    int          nr;
    logic        we;
    logic [31:0] addr;
    for (int i = 0; i < 16; i++) begin smem[i] = $urandom; mmem[i] = smem[i]; end
    smem[0] = 32'hFFFFFFFF; mmem[0] = 32'hFFFFFFFF;
    drop_req();
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_ctrl", {bus.axi_arvalid, bus.axi_rready, bus.axi_awvalid, bus.axi_wvalid,
                       bus.axi_bready, bus.resp_valid, bus.resp_err}, 0);
    check("rst_addr", {bus.axi_araddr, bus.axi_awaddr}, 0);
    check("rst_data", {bus.axi_wdata, bus.resp_rdata}, 0);
    check("rst_misc", {bus.axi_wstrb, bus.axi_arprot, bus.axi_awprot}, 0);
    rst = 1'b0;

    // Always-ready read from the CLINT-style window.
    issue(1'b0, 32'h4000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    check("t1_arvalid_c1", bus.axi_arvalid, 1);
    check("t1_req_ready_c1", bus.req_ready, 0);
    @(negedge clk);
    check("t1_arvalid_c2", bus.axi_arvalid, 0);
    check("t1_rready_c2", bus.axi_rready, 1);
    @(negedge clk);
    check("t1_resp_c3", bus.resp_valid, 1);
    check("t1_req_ready_c3", bus.req_ready, 1);
    check("t1_rdata", bus.resp_rdata, 32'hFFFFFFFF);
    wait_done(50);

    // Write with a slow address channel, then read it back.
    issue(1'b1, 32'h4004, 32'h12345678, 4'hF, 0, 0, 3, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    wait_done(50);
    issue(1'b0, 32'h4004, 32'h0, 4'h0, 1, 1, 0, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    wait_done(50);
    check("t2_readback", bus.resp_rdata, 32'h12345678);

    // Error responses.
    issue(1'b0, 32'h0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    wait_done(50);
    check("t3_rd_err_hold", bus.resp_err, 1);
    issue(1'b1, 32'h0000, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 1, 2'b11, wr);
    @(negedge clk); drop_req();
    wait_done(50);
    check("t3_wr_err_hold", {bus.resp_err, bus.resp_rdata}, {1'b1, 32'h0});

    // Back-to-back: second request held until the first completes.
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, wr);
    issue(1'b1, 32'h400C, 32'hA5A55A5A, 4'h5, 0, 0, 0, 2, 0, 2'b10, wr);
    check("t4_accept_with_resp", wr, 1);
    @(negedge clk); drop_req();
    wait_done(50);

    // Stalled read: rvalid withheld 10 cycles.
    issue(1'b0, 32'h4000, 32'h0, 4'h0, 0, 10, 0, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    bad = 1'b0;
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      if (!bus.axi_rready || bus.req_ready || bus.resp_valid) bad = 1'b1;
    end
    check("t5_stall", bad, 0);
    wait_done(50);

    // Reset in the middle of a write whose address phase is stalled.
    issue(1'b1, 32'h4010, 32'h11223344, 4'hF, 0, 0, 3, 0, 0, 2'b10, wr);
    @(negedge clk); drop_req();
    check("t6_awvalid_before", bus.axi_awvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_ctrl_async", {bus.axi_arvalid, bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready,
                            bus.axi_rready, bus.resp_valid}, 0);
    check("t6_req_ready_async", bus.req_ready, 1);
    check("t6_rdata_rst", bus.resp_rdata, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    nr = n_resp;
    repeat (5) @(negedge clk);
    check("t6_req_ready_after", bus.req_ready, 1);
    check("t6_no_resp", n_resp, nr);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 15)) << 2
                                         : 32'h4000 + (32'($urandom_range(0, 15)) << 2);
      issue(we, addr, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 4), 2'($urandom_range(2, 3)), wr);
      if ($urandom_range(0, 3) == 0) continue;
      @(negedge clk); drop_req();
      wait_done(100);
    end
    @(negedge clk); drop_req();
    wait_done(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
